// File: rtl/led_matrix_scan_pkg.sv
// Shared display constants, scan states and the map flattening rule used by
// both the snake movement stage and the LED scanner.
package snek_display_pkg;

   localparam int COLS      = 12;
   localparam int ROWS      = 9;
   localparam int MAP_BITS  = COLS * ROWS;
   localparam int MAP_IDX_W = $clog2(MAP_BITS);
   localparam int ROW_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   function automatic logic [MAP_IDX_W-1:0] map_index(input int x, input int y);
      return MAP_IDX_W'(x * ROWS + y);
   endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Map input from the movement stage and LED pin drive, bundled for the scanner.
interface led_matrix_scan_if;

   logic                                   scan_en;
   logic [snek_display_pkg::MAP_BITS-1:0]  map_in;
   logic                                   map_valid;
   logic [snek_display_pkg::ROWS-1:0]      row_sel;
   logic [snek_display_pkg::COLS-1:0]      col_data;
   logic                                   frame_done;
   logic [snek_display_pkg::ROW_IDX_W-1:0] row_idx;

   modport master (
      output scan_en, map_in, map_valid,
      input  row_sel, col_data, frame_done, row_idx
   );

   modport slave (
      input  scan_en, map_in, map_valid,
      output row_sel, col_data, frame_done, row_idx
   );

endinterface

// File: rtl/led_matrix_scan_phase_timer.sv
// Loadable down-counter timing one scan phase; done while the count sits at zero.
module phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix scanner with double-buffered map and tear-free swap.
//
//   state | meaning
//   IDLE  | outputs off, waiting for scan_en and a pending map
//   BLANK | outputs off between rows to suppress ghosting
//   DRIVE | row_idx row driven with its column data for the dwell time
module led_matrix_scan
   import snek_display_pkg::*;
#(
   parameter int DWELL_CYCLES   = 5000,
   parameter int BLANK_CYCLES   = 50,
   parameter bit ROW_ACTIVE_LOW = 1'b0,
   parameter bit COL_ACTIVE_LOW = 1'b0
) (
   input logic              clk,
   input logic              reset_n,
   led_matrix_scan_if.slave bus
);

   localparam int MAX_PHASE = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W     = $clog2(MAX_PHASE + 1);
   localparam logic [CNT_W-1:0]     DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0]     BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [ROW_IDX_W-1:0] LAST_ROW   = ROW_IDX_W'(ROWS - 1);
   localparam logic [ROWS-1:0]      ROW_OFF    = {ROWS{ROW_ACTIVE_LOW}};
   localparam logic [COLS-1:0]      COL_OFF    = {COLS{COL_ACTIVE_LOW}};

   scan_state_e          state_q, state_d;
   logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
   logic [MAP_BITS-1:0]  pending_q, pending_d;
   logic [MAP_BITS-1:0]  active_q, active_d;
   logic                 pending_flag_q, pending_flag_d;
   logic                 frame_done_q, frame_done_d;
   logic [ROWS-1:0]      row_sel_q, row_sel_d;
   logic [COLS-1:0]      col_data_q, col_data_d;

   logic                 swap;
   logic                 start_row;
   logic                 tmr_load;
   logic [CNT_W-1:0]     tmr_val;
   logic                 tmr_done;

   phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_d      = state_q;
      row_idx_d    = row_idx_q;
      frame_done_d = 1'b0;
      swap         = 1'b0;
      start_row    = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = DWELL_LOAD;

      if (!bus.scan_en) begin
         state_d   = IDLE;
         row_idx_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pending_flag_q) begin
                  swap      = 1'b1;
                  row_idx_d = '0;
                  start_row = 1'b1;
               end
            end
            BLANK: begin
               if (tmr_done) begin
                  state_d  = DRIVE;
                  tmr_load = 1'b1;
                  tmr_val  = DWELL_LOAD;
               end
            end
            DRIVE: begin
               if (tmr_done) begin
                  start_row = 1'b1;
                  if (row_idx_q == LAST_ROW) begin
                     row_idx_d    = '0;
                     frame_done_d = 1'b1;
                     swap         = pending_flag_q;
                  end else begin
                     row_idx_d = row_idx_q + ROW_IDX_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // With no blank phase a new row goes straight back to DRIVE.
      if (start_row) begin
         tmr_load = 1'b1;
         if (BLANK_CYCLES == 0) begin
            state_d = DRIVE;
            tmr_val = DWELL_LOAD;
         end else begin
            state_d = BLANK;
            tmr_val = BLANK_LOAD;
         end
      end
   end

   // Swap reads the old pending map; a same-edge strobe refills pending and keeps the flag.
   always_comb begin
      pending_d      = bus.map_valid ? bus.map_in : pending_q;
      active_d       = swap ? pending_q : active_q;
      pending_flag_d = bus.map_valid | (pending_flag_q & ~swap);
   end

   always_comb begin
      row_sel_d  = ROW_OFF;
      col_data_d = COL_OFF;
      if (state_q == DRIVE) begin
         row_sel_d = ROW_OFF ^ (ROWS'(1) << row_idx_q);
         for (int c = 0; c < COLS; c++) begin
            col_data_d[c] = COL_OFF[c] ^ active_q[map_index(c, int'(row_idx_q))];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         row_idx_q      <= '0;
         pending_q      <= '0;
         active_q       <= '0;
         pending_flag_q <= 1'b0;
         frame_done_q   <= 1'b0;
         row_sel_q      <= ROW_OFF;
         col_data_q     <= COL_OFF;
      end else begin
         state_q        <= state_d;
         row_idx_q      <= row_idx_d;
         pending_q      <= pending_d;
         active_q       <= active_d;
         pending_flag_q <= pending_flag_d;
         frame_done_q   <= frame_done_d;
         row_sel_q      <= row_sel_d;
         col_data_q     <= col_data_d;
      end
   end

   assign bus.row_sel    = row_sel_q;
   assign bus.col_data   = col_data_q;
   assign bus.frame_done = frame_done_q;
   assign bus.row_idx    = row_idx_q;

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
Consumes the 12x9 occupancy map produced by the snake movement stage and drives a row-multiplexed LED matrix, one row at a time. The map is captured into a pending buffer whenever the movement stage signals a stable map. The pending buffer is promoted to the displayed buffer only at a frame boundary, so the display never tears. A blanking gap separates rows to suppress ghosting. The block sits directly downstream of the movement logic and drives the board pins.

Parameters:
COLS, 12, number of columns (x dimension of map)
ROWS, 9, number of rows (y dimension of map)
DWELL_CYCLES, 5000, clocks each row is driven; must be >= 1
BLANK_CYCLES, 50, clocks all outputs inactive between rows; 0 = no blank phase
ROW_ACTIVE_LOW, 0, 1 = row_sel active-low at pins
COL_ACTIVE_LOW, 0, 1 = col_data active-low at pins

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
scan_en  in  1  1 = scanning allowed; 0 = force IDLE
map_in  in  COLS*ROWS  flattened map; bit index = x*ROWS + y (x 0..11, y 0..8)
map_valid  in  1  one-cycle strobe: map_in is stable, capture it
row_sel  out  ROWS  one-hot row drive; bit r = y row r (polarity per ROW_ACTIVE_LOW)
col_data  out  COLS  column data; bit c = active[c*ROWS + current_row] (polarity per COL_ACTIVE_LOW)
frame_done  out  1  one-cycle pulse at each completed frame
row_idx  out  4  current row index, for debug

Behaviour:
- Reset (async, reset_n=0) sets: state IDLE, row_idx 0, pending and active buffers all 0, pending_flag 0, frame_done 0. row_sel and col_data are at their inactive level (all 0, or all 1 if the matching ACTIVE_LOW parameter is 1).
- Capture: on a clk edge with map_valid=1, pending <= map_in and pending_flag <= 1. Capture happens in every state, including IDLE and when scan_en=0.
- FSM states are IDLE, BLANK and DRIVE. A down-counter times each phase and is loaded with (phase length - 1).
- IDLE: outputs inactive. Leave IDLE when scan_en=1 and pending_flag=1. On that edge: active <= pending, pending_flag <= 0 (unless map_valid=1 on the same edge), row_idx <= 0, go to BLANK. If BLANK_CYCLES=0, go straight to DRIVE.
- BLANK: outputs inactive for BLANK_CYCLES clocks, then go to DRIVE.
- DRIVE: row_sel[row_idx] is active and col_data shows the active row, for DWELL_CYCLES clocks. At expiry:
  - If row_idx < ROWS-1: row_idx increments and the FSM goes to BLANK (or DRIVE if BLANK_CYCLES=0).
  - If row_idx = ROWS-1 (frame boundary): row_idx wraps to 0. frame_done=1 for exactly the next cycle. If pending_flag=1, active <= pending and pending_flag clears. Otherwise active is unchanged and the last map is redisplayed.
- Simultaneous map_valid and swap on the same edge: the swap takes the old pending contents, the new map_in is written to pending, and pending_flag stays 1. The new map appears on the next frame.
- scan_en=0 in any state: go to IDLE on the next edge, outputs inactive the following cycle, row_idx <= 0. The active buffer is retained. On re-enable with pending_flag=0, the FSM stays in IDLE until the next map_valid.
- Outputs are registered: row_sel and col_data change one cycle after a state or row_idx change, never combinationally from map_in.
- Frame period = ROWS*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- Counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- row_idx never exceeds ROWS-1.

Decomposition:
- Package snek_display_pkg holds:
  - COLS, ROWS, MAP_BITS (= COLS*ROWS)
  - scan state enum {IDLE, BLANK, DRIVE}
  - function map_index(x, y) = x*ROWS + y, shared with the movement stage's flattening.
- One sub-module, phase_timer: loadable down-counter with load value, load strobe and a done flag (done when count=0).

Test Plan (bench uses DWELL_CYCLES=4, BLANK_CYCLES=2):
- Reset with scan_en=1 and no map_valid -> state stays IDLE; row_sel=0, col_data=0, frame_done never asserts over 200 cycles.
- map_valid with only bits x=4,y=2..4 set (indices 38,39,40) -> first DRIVE of rows 2,3,4 shows col_data=12'h010; other rows show 0. frame_done pulses 54 cycles after the first BLANK entry.
- New map (x=5,y=4, index 49) strobed mid-frame at row 3 -> rows 3..8 of the current frame still show the old map; the next frame's row 4 shows col_data=12'h020; frame_done pulses at the boundary.
- map_valid on the exact frame-boundary edge -> the swap uses the earlier pending map, pending_flag stays 1, and the strobed map appears in the frame after.
- scan_en dropped during DRIVE of row 5 -> outputs inactive within 2 cycles, row_idx=0. On re-enable with no new map_valid, the FSM stays in IDLE.
- ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=1 and reset_n asserted mid-DRIVE -> row_sel=9'h1FF and col_data=12'hFFF immediately (asynchronously). Buffers clear, so a later enable waits for map_valid.
